// File: rtl/nv_nvdla_pdp_cal1d_info_fifo_ctrl_pkg.sv
// Shared PDP cal1d info FIFO constants: geometry, pointer/count widths and the
// RAM read-select code that routes the write data straight to the read port.
package nv_nvdla_pdp_cal1d_info_fifo_ctrl_pkg;

  localparam int PDP_INFO_DEPTH = 8;
  localparam int PDP_INFO_WIDTH = 12;
  localparam int PDP_INFO_PTR_W = 3;
  localparam int PDP_INFO_CNT_W = 4;

  localparam logic [PDP_INFO_CNT_W-1:0] PDP_INFO_BYPASS_SEL = 4'd8;

endpackage

// File: rtl/nv_nvdla_pdp_cal1d_info_fifo_ctrl.sv
// Controller for the PDP cal1d info FIFO. The RAM lives in the parent; an empty
// FIFO with a ready reader hands the write word straight through (ram_ra = 8).
module nv_nvdla_pdp_cal1d_info_fifo_ctrl
  import nv_nvdla_pdp_cal1d_info_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = PDP_INFO_DEPTH,
  parameter int WIDTH = PDP_INFO_WIDTH
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic                      wr_pvld,
  output logic                      wr_prdy,
  input  logic [WIDTH-1:0]          wr_pd,
  output logic                      rd_pvld,
  input  logic                      rd_prdy,
  output logic [WIDTH-1:0]          rd_pd,
  output logic                      ram_we,
  output logic [PDP_INFO_PTR_W-1:0] ram_wa,
  output logic [WIDTH-1:0]          ram_di,
  output logic [PDP_INFO_CNT_W-1:0] ram_ra,
  input  logic [WIDTH-1:0]          ram_dout,
  output logic [PDP_INFO_CNT_W-1:0] fifo_count,
  output logic                      fifo_idle
);

  localparam logic [PDP_INFO_CNT_W-1:0] FULL_CNT = PDP_INFO_CNT_W'(DEPTH);

  logic [PDP_INFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PDP_INFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PDP_INFO_CNT_W-1:0] count_q, count_d;

  logic empty_s;
  logic wr_acc_s;
  logic rd_acc_s;
  logic bypass_s;
  logic ram_rd_s;

  // Handshake, bypass decision and RAM port drive.
  always_comb begin
    empty_s  = (count_q == 4'd0);
    wr_prdy  = (count_q != FULL_CNT);
    wr_acc_s = wr_pvld & wr_prdy;
    if (empty_s) begin
      rd_pvld = wr_pvld;
      ram_ra  = PDP_INFO_BYPASS_SEL;
    end else begin
      rd_pvld = 1'b1;
      ram_ra  = {1'b0, rd_ptr_q};
    end
    rd_acc_s   = rd_pvld & rd_prdy;
    bypass_s   = empty_s & wr_acc_s & rd_prdy;
    ram_we     = wr_acc_s & ~bypass_s;
    ram_rd_s   = rd_acc_s & ~empty_s;
    ram_wa     = wr_ptr_q;
    ram_di     = wr_pd;
    rd_pd      = ram_dout;
    fifo_count = count_q;
    fifo_idle  = empty_s & ~wr_pvld;
  end

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ram_we) begin
      wr_ptr_d = wr_ptr_q + 3'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (ram_rd_s) begin
      rd_ptr_d = rd_ptr_q + 3'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({ram_we, ram_rd_s})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards held entries but leaves the RAM alone.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_pdp_cal1d_info_fifo_ctrl.sv
// Directed bench for the cal1d info FIFO controller with a behavioural RAM
// (combinational read, select 8 returns the write data).
module tb_nv_nvdla_pdp_cal1d_info_fifo_ctrl;

  logic        clk;
  logic        rstn;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [11:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [11:0] rd_pd;
  logic        ram_we;
  logic [2:0]  ram_wa;
  logic [11:0] ram_di;
  logic [3:0]  ram_ra;
  logic [11:0] ram_dout;
  logic [3:0]  fifo_count;
  logic        fifo_idle;

  logic [11:0] mem [0:7];

  int n_tests = 0;
  int n_fail  = 0;

  nv_nvdla_pdp_cal1d_info_fifo_ctrl #(.DEPTH(8), .WIDTH(12)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .ram_we         (ram_we),
    .ram_wa         (ram_wa),
    .ram_di         (ram_di),
    .ram_ra         (ram_ra),
    .ram_dout       (ram_dout),
    .fifo_count     (fifo_count),
    .fifo_idle      (fifo_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
  end

  assign ram_dout = (ram_ra == 4'd8) ? ram_di : mem[ram_ra[2:0]];

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = 12'h000;
    #2;
    n_tests++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_prdy got %b exp 1", wr_prdy); end
    n_tests++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pvld got %b exp 0", rd_pvld); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    n_tests++; if (ram_ra !== 4'd8) begin n_fail++; $display("FAIL reset_ram_ra got %0d exp 8", ram_ra); end
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    n_tests++; if (fifo_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", fifo_idle); end
    #10 rstn = 1'b1;
    cycle();
    n_tests++; if (fifo_count !== 4'd0 || wr_prdy !== 1'b1 || fifo_idle !== 1'b1) begin
      n_fail++; $display("FAIL post_reset count=%0d wr_prdy=%b idle=%b exp 0/1/1", fifo_count, wr_prdy, fifo_idle);
    end
  endtask

  task automatic test_bypass();
    wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 12'hABC;
    #1;
    n_tests++; if (rd_pvld !== 1'b1) begin n_fail++; $display("FAIL bypass_rd_pvld got %b exp 1", rd_pvld); end
    n_tests++; if (rd_pd !== 12'hABC) begin n_fail++; $display("FAIL bypass_rd_pd got %h exp abc", rd_pd); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL bypass_ram_we got %b exp 0", ram_we); end
    n_tests++; if (ram_ra !== 4'd8) begin n_fail++; $display("FAIL bypass_ram_ra got %0d exp 8", ram_ra); end
    n_tests++; if (fifo_idle !== 1'b0) begin n_fail++; $display("FAIL bypass_idle got %b exp 0", fifo_idle); end
    cycle();
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL bypass_count got %0d exp 0", fifo_count); end
    n_tests++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL bypass_idle_rd_pvld got %b exp 0", rd_pvld); end
  endtask

  task automatic test_fill_and_full_read();
    logic [11:0] exp_d;
    rd_prdy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr_pvld = 1'b1; wr_pd = 12'(i);
      #1;
      n_tests++; if (ram_we !== 1'b1 || ram_wa !== 3'(i - 1)) begin
        n_fail++; $display("FAIL fill_write_%0d ram_we=%b ram_wa=%0d exp 1/%0d", i, ram_we, ram_wa, i - 1);
      end
      cycle();
    end
    wr_pvld = 1'b1; wr_pd = 12'h009;
    #1;
    n_tests++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d exp 8", fifo_count); end
    n_tests++; if (wr_prdy !== 1'b0) begin n_fail++; $display("FAIL fill_wr_prdy got %b exp 0", wr_prdy); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL ninth_ram_we got %b exp 0", ram_we); end
    n_tests++; if (rd_pd !== 12'h001) begin n_fail++; $display("FAIL full_head got %h exp 001", rd_pd); end
    cycle();
    n_tests++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL ninth_count got %0d exp 8", fifo_count); end
    // read while full with a write still requested
    rd_prdy = 1'b1;
    #1;
    n_tests++; if (ram_we !== 1'b0 || rd_pd !== 12'h001) begin
      n_fail++; $display("FAIL full_rd ram_we=%b rd_pd=%h exp 0/001", ram_we, rd_pd);
    end
    cycle();
    wr_pvld = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd7 || wr_prdy !== 1'b1) begin
      n_fail++; $display("FAIL full_rd_after count=%0d wr_prdy=%b exp 7/1", fifo_count, wr_prdy);
    end
    for (int i = 2; i <= 8; i++) begin
      exp_d = 12'(i);
      n_tests++; if (rd_pvld !== 1'b1 || rd_pd !== exp_d) begin
        n_fail++; $display("FAIL drain_%0d rd_pvld=%b rd_pd=%h exp 1/%h", i, rd_pvld, rd_pd, exp_d);
      end
      cycle();
    end
    rd_prdy = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd0 || rd_pvld !== 1'b0 || fifo_idle !== 1'b1) begin
      n_fail++; $display("FAIL drain_end count=%0d rd_pvld=%b idle=%b exp 0/0/1", fifo_count, rd_pvld, fifo_idle);
    end
  endtask

  task automatic test_stall();
    rd_prdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_pvld = 1'b1; wr_pd = 12'h031 + 12'(i);
      cycle();
    end
    wr_pvld = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL stall_count got %0d exp 3", fifo_count); end
    for (int c = 0; c < 5; c++) begin
      n_tests++; if (rd_pvld !== 1'b1 || rd_pd !== 12'h031) begin
        n_fail++; $display("FAIL stall_hold_%0d rd_pvld=%b rd_pd=%h exp 1/031", c, rd_pvld, rd_pd);
      end
      cycle();
    end
    rd_prdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (rd_pd !== 12'h031 + 12'(i)) begin
        n_fail++; $display("FAIL stall_drain_%0d got %h exp %h", i, rd_pd, 12'h031 + 12'(i));
      end
      cycle();
    end
    rd_prdy = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL stall_end_count got %0d exp 0", fifo_count); end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_q [$];
    logic [11:0] exp_d;
    int sent = 0;
    int rcvd = 0;
    int cnt_m = 0;
    logic w_acc, r_acc, byp, we_m, rv_m;
    for (int cyc = 0; cyc < 200 && rcvd < 20; cyc++) begin
      wr_pvld = (sent < 20);
      wr_pd   = 12'h100 + 12'(sent);
      rd_prdy = (cyc % 2 == 0);
      #1;
      w_acc = wr_pvld && (cnt_m != 8);
      rv_m  = (cnt_m > 0) || wr_pvld;
      r_acc = rv_m && rd_prdy;
      byp   = (cnt_m == 0) && w_acc && rd_prdy;
      we_m  = w_acc && !byp;
      n_tests++; if (wr_prdy !== (cnt_m != 8) || rd_pvld !== rv_m || ram_we !== we_m) begin
        n_fail++; $display("FAIL wrap_hs_%0d wr_prdy=%b rd_pvld=%b ram_we=%b exp %b/%b/%b",
                           cyc, wr_prdy, rd_pvld, ram_we, cnt_m != 8, rv_m, we_m);
      end
      if (w_acc) begin
        exp_q.push_back(wr_pd);
        sent++;
      end
      if (r_acc) begin
        exp_d = exp_q.pop_front();
        rcvd++;
        n_tests++; if (rd_pd !== exp_d) begin
          n_fail++; $display("FAIL wrap_data_%0d got %h exp %h", rcvd, rd_pd, exp_d);
        end
      end
      if (we_m && !(r_acc && cnt_m > 0)) cnt_m++;
      else if (!we_m && r_acc && cnt_m > 0) cnt_m--;
      cycle();
    end
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    #1;
    n_tests++; if (rcvd != 20 || fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL wrap_done rcvd=%0d count=%0d exp 20/0", rcvd, fifo_count);
    end
  endtask

  task automatic test_reset_midstream();
    rd_prdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_pvld = 1'b1; wr_pd = 12'h200 + 12'(i);
      cycle();
    end
    wr_pvld = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd5) begin n_fail++; $display("FAIL mid_count got %0d exp 5", fifo_count); end
    rstn = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd0 || rd_pvld !== 1'b0 || wr_prdy !== 1'b1 || fifo_idle !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset count=%0d rd_pvld=%b wr_prdy=%b idle=%b exp 0/0/1/1",
                         fifo_count, rd_pvld, wr_prdy, fifo_idle);
    end
    #3 rstn = 1'b1;
    cycle();
    wr_pvld = 1'b1; rd_prdy = 1'b1; wr_pd = 12'h5A5;
    #1;
    n_tests++; if (ram_we !== 1'b0 || ram_ra !== 4'd8 || rd_pd !== 12'h5A5 || rd_pvld !== 1'b1) begin
      n_fail++; $display("FAIL mid_first_bypass ram_we=%b ram_ra=%0d rd_pd=%h rd_pvld=%b exp 0/8/5a5/1",
                         ram_we, ram_ra, rd_pd, rd_pvld);
    end
    cycle();
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    #1;
    n_tests++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL mid_end_count got %0d exp 0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill_and_full_read();
    test_stall();
    test_wrap();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
